// File: rtl/ariane_pkg.sv
// Shared core types. The commit-stage scoreboard entry and the trace entry
// live together so the trace FIFO and the commit stage agree on field layout.
package ariane_pkg;

  localparam int unsigned VLEN = 64;
  localparam int unsigned XLEN = 64;

  typedef enum logic [3:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    MULT,
    CSR,
    FPU
  } fu_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    fu_t             fu;
    logic            valid;
  } scoreboard_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    fu_t             fu;
    logic            is_ex;
    logic [XLEN-1:0] cause;
    logic [15:0]     seq;
  } trace_entry_t;

endpackage

// File: rtl/commit_trace_if.sv
// Consumer-side handshake of the commit trace FIFO: head entry plus valid/ready.
interface commit_trace_if;
  import ariane_pkg::*;

  logic         trace_valid_o;
  logic         trace_ready_i;
  trace_entry_t trace_o;

  modport master (
    output trace_valid_o,
    output trace_o,
    input  trace_ready_i
  );

  modport slave (
    input  trace_valid_o,
    input  trace_o,
    output trace_ready_i
  );

endinterface

// File: rtl/commit_trace_fifo.sv
// Passive observer of the commit stage: records retired instructions and taken
// exceptions into a 2-write/1-read FIFO, dropping and counting what does not fit.
module commit_trace_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic                                     en_i,
  input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0]  commit_instr_i,
  input  logic [NR_COMMIT_PORTS-1:0]               commit_ack_i,
  input  exception_t                               exception_i,
  commit_trace_if.master                           trace,
  output logic [$clog2(DEPTH):0]                   level_o,
  output logic [15:0]                              overflow_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  trace_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [LW-1:0]  level_q;
  logic [15:0]    seq_q;
  logic [15:0]    ovf_q;

  trace_entry_t   wr_entry0, wr_entry1;
  logic [1:0]     n_req, n_wr, n_drop;
  logic [LW-1:0]  free_slots;
  logic [16:0]    ovf_sum;
  logic           pop;
  logic           unused_valid;

  // Build up to two compacted write requests; an exception overrides all acks.
  always_comb begin
    wr_entry0 = '0;
    wr_entry1 = '0;
    n_req     = 2'd0;
    if (en_i) begin
      if (exception_i.valid && commit_instr_i[0].valid) begin
        wr_entry0.pc    = commit_instr_i[0].pc;
        wr_entry0.fu    = commit_instr_i[0].fu;
        wr_entry0.is_ex = 1'b1;
        wr_entry0.cause = exception_i.cause;
        n_req           = 2'd1;
      end else begin
        for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
          if (commit_ack_i[i]) begin
            if (n_req == 2'd0) begin
              wr_entry0.pc = commit_instr_i[i].pc;
              wr_entry0.fu = commit_instr_i[i].fu;
            end else begin
              wr_entry1.pc = commit_instr_i[i].pc;
              wr_entry1.fu = commit_instr_i[i].fu;
            end
            n_req = n_req + 2'd1;
          end
        end
      end
    end
    wr_entry0.seq = seq_q;
    wr_entry1.seq = seq_q + 16'd1;
  end

  // Space is judged on start-of-cycle occupancy, so a same-cycle pop never helps.
  always_comb begin
    free_slots = LW'(DEPTH) - level_q;
    n_wr       = ({{(LW-2){1'b0}}, n_req} > free_slots) ? free_slots[1:0] : n_req;
    n_drop     = n_req - n_wr;
    ovf_sum    = {1'b0, ovf_q} + 17'(n_drop);
    pop        = (level_q != '0) && trace.trace_ready_i;
  end

  always_comb begin
    unused_valid = 1'b0;
    for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
      unused_valid = unused_valid ^ commit_instr_i[i].valid;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      seq_q   <= '0;
      ovf_q   <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(n_wr);
      rptr_q  <= rptr_q + AW'(pop);
      level_q <= level_q + LW'(n_wr) - LW'(pop);
      seq_q   <= seq_q + 16'(n_wr);
      ovf_q   <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end
  end

  // Storage carries no reset; stale contents are hidden behind trace_valid_o.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      if (n_wr != 2'd0) mem_q[wptr_q] <= wr_entry0;
      if (n_wr == 2'd2) mem_q[wptr_q + AW'(1)] <= wr_entry1;
    end
  end

  assign trace.trace_valid_o = (level_q != '0);
  assign trace.trace_o       = mem_q[rptr_q];
  assign level_o             = level_q;
  assign overflow_cnt_o      = ovf_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed scenarios for commit_trace_fifo with hand-derived expected values.
module tb_commit_trace_fifo;
  import ariane_pkg::*;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    flush_i;
  logic                    en_i;
  scoreboard_entry_t [1:0] commit_instr;
  logic [1:0]              commit_ack;
  exception_t              exception;
  logic [4:0]              level;
  logic [15:0]             ovf;

  int          chk_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] exp_ovf = 16'd0;

  commit_trace_if tr();

  commit_trace_fifo #(.NR_COMMIT_PORTS(2), .DEPTH(16)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .en_i           (en_i),
    .commit_instr_i (commit_instr),
    .commit_ack_i   (commit_ack),
    .exception_i    (exception),
    .trace          (tr),
    .level_o        (level),
    .overflow_cnt_o (ovf)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle();
    flush_i          = 1'b0;
    en_i             = 1'b1;
    commit_ack       = 2'b00;
    exception        = '0;
    tr.trace_ready_i = 1'b0;
  endtask

  task automatic set_ports(input logic [63:0] pc0, input logic [63:0] pc1, input logic [1:0] ack);
    commit_instr[0].pc    = pc0;
    commit_instr[0].fu    = ALU;
    commit_instr[0].valid = 1'b1;
    commit_instr[1].pc    = pc1;
    commit_instr[1].fu    = LOAD;
    commit_instr[1].valid = 1'b1;
    commit_ack            = ack;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle();
    set_ports(64'h0, 64'h0, 2'b00);
    #12;
    chk_cnt++; if (tr.trace_valid_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_valid got %b want 0", tr.trace_valid_o); end
    chk_cnt++; if (level !== 5'd0) begin err_cnt++; $display("[TB] FAIL reset_level got %0d want 0", level); end
    chk_cnt++; if (ovf !== 16'd0) begin err_cnt++; $display("[TB] FAIL reset_ovf got %h want 0000", ovf); end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_two_port();
    set_ports(64'h8000_0000, 64'h8000_0004, 2'b11);
    tr.trace_ready_i = 1'b1;
    step();
    commit_ack = 2'b00;
    chk_cnt++; if (level !== 5'd2) begin err_cnt++; $display("[TB] FAIL two_level got %0d want 2", level); end
    chk_cnt++; if (tr.trace_o.pc !== 64'h8000_0000) begin err_cnt++; $display("[TB] FAIL two_pc0 got %h want 80000000", tr.trace_o.pc); end
    chk_cnt++; if (tr.trace_o.seq !== 16'd0) begin err_cnt++; $display("[TB] FAIL two_seq0 got %0d want 0", tr.trace_o.seq); end
    chk_cnt++; if (tr.trace_o.fu !== ALU || tr.trace_o.is_ex !== 1'b0 || tr.trace_o.cause !== 64'd0) begin
      err_cnt++; $display("[TB] FAIL two_fields got fu=%0d ex=%b cause=%h want fu=ALU ex=0 cause=0", tr.trace_o.fu, tr.trace_o.is_ex, tr.trace_o.cause);
    end
    step();
    chk_cnt++; if (tr.trace_o.pc !== 64'h8000_0004) begin err_cnt++; $display("[TB] FAIL two_pc1 got %h want 80000004", tr.trace_o.pc); end
    chk_cnt++; if (tr.trace_o.seq !== 16'd1) begin err_cnt++; $display("[TB] FAIL two_seq1 got %0d want 1", tr.trace_o.seq); end
    chk_cnt++; if (tr.trace_o.fu !== LOAD) begin err_cnt++; $display("[TB] FAIL two_fu1 got %0d want LOAD", tr.trace_o.fu); end
    step();
    chk_cnt++; if (tr.trace_valid_o !== 1'b0 || level !== 5'd0) begin err_cnt++; $display("[TB] FAIL two_empty got valid=%b level=%0d want 0/0", tr.trace_valid_o, level); end
    tr.trace_ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 7; i++) begin
      set_ports(64'h100 + 64'(i * 8), 64'h104 + 64'(i * 8), 2'b11);
      step();
    end
    set_ports(64'h200, 64'h204, 2'b01);
    step();
    chk_cnt++; if (level !== 5'd15) begin err_cnt++; $display("[TB] FAIL ovf_fill got %0d want 15", level); end
    set_ports(64'h1000, 64'h1004, 2'b11);
    tr.trace_ready_i = 1'b1;
    step();
    commit_ack       = 2'b00;
    tr.trace_ready_i = 1'b0;
    exp_ovf          = 16'd1;
    chk_cnt++; if (level !== 5'd15) begin err_cnt++; $display("[TB] FAIL ovf_level got %0d want 15", level); end
    chk_cnt++; if (ovf !== exp_ovf) begin err_cnt++; $display("[TB] FAIL ovf_count got %0d want %0d", ovf, exp_ovf); end
    chk_cnt++; if (tr.trace_o.seq !== 16'd3) begin err_cnt++; $display("[TB] FAIL ovf_head_seq got %0d want 3", tr.trace_o.seq); end
  endtask

  task automatic test_flush();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk_cnt++; if (level !== 5'd0) begin err_cnt++; $display("[TB] FAIL flush_empty got %0d want 0", level); end
    set_ports(64'h500, 64'h504, 2'b11); step();
    set_ports(64'h508, 64'h50c, 2'b11); step();
    set_ports(64'h510, 64'h514, 2'b01); step();
    chk_cnt++; if (level !== 5'd5) begin err_cnt++; $display("[TB] FAIL flush_fill got %0d want 5", level); end
    chk_cnt++; if (tr.trace_o.seq !== 16'd18) begin err_cnt++; $display("[TB] FAIL flush_head_seq got %0d want 18", tr.trace_o.seq); end
    set_ports(64'h600, 64'h604, 2'b01);
    flush_i          = 1'b1;
    tr.trace_ready_i = 1'b1;
    step();
    flush_i          = 1'b0;
    tr.trace_ready_i = 1'b0;
    commit_ack       = 2'b00;
    chk_cnt++; if (level !== 5'd0 || tr.trace_valid_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL flush_level got %0d valid=%b want 0/0", level, tr.trace_valid_o); end
    chk_cnt++; if (ovf !== exp_ovf) begin err_cnt++; $display("[TB] FAIL flush_ovf got %0d want %0d", ovf, exp_ovf); end
    set_ports(64'h2000, 64'h2004, 2'b01);
    step();
    commit_ack = 2'b00;
    chk_cnt++; if (tr.trace_o.seq !== 16'd23) begin err_cnt++; $display("[TB] FAIL flush_seq got %0d want 23", tr.trace_o.seq); end
    chk_cnt++; if (tr.trace_o.pc !== 64'h2000) begin err_cnt++; $display("[TB] FAIL flush_pc got %h want 2000", tr.trace_o.pc); end
  endtask

  task automatic test_exception();
    flush_i = 1'b1;
    step();
    flush_i         = 1'b0;
    exception.valid = 1'b1;
    exception.cause = 64'd2;
    set_ports(64'h3000, 64'h3004, 2'b11);
    step();
    exception  = '0;
    commit_ack = 2'b00;
    chk_cnt++; if (level !== 5'd1) begin err_cnt++; $display("[TB] FAIL ex_level got %0d want 1", level); end
    chk_cnt++; if (tr.trace_o.is_ex !== 1'b1 || tr.trace_o.cause !== 64'd2) begin err_cnt++; $display("[TB] FAIL ex_fields got ex=%b cause=%h want 1/2", tr.trace_o.is_ex, tr.trace_o.cause); end
    chk_cnt++; if (tr.trace_o.pc !== 64'h3000 || tr.trace_o.seq !== 16'd24) begin err_cnt++; $display("[TB] FAIL ex_pc_seq got %h/%0d want 3000/24", tr.trace_o.pc, tr.trace_o.seq); end
    step();
    chk_cnt++; if (level !== 5'd1) begin err_cnt++; $display("[TB] FAIL ex_single got %0d want 1", level); end
  endtask

  task automatic test_saturate();
    int gap;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_ports(64'h700, 64'h704, 2'b11);
      step();
    end
    chk_cnt++; if (level !== 5'd16) begin err_cnt++; $display("[TB] FAIL sat_full got %0d want 16", level); end
    gap = 32'hFFFE - int'(exp_ovf);
    if (gap % 2 == 1) begin
      set_ports(64'h700, 64'h704, 2'b01);
      step();
      gap = gap - 1;
    end
    set_ports(64'h700, 64'h704, 2'b11);
    for (int i = 0; i < gap / 2; i++) step();
    exp_ovf = 16'hFFFE;
    chk_cnt++; if (ovf !== exp_ovf) begin err_cnt++; $display("[TB] FAIL sat_preload got %h want %h", ovf, exp_ovf); end
    step();
    exp_ovf = 16'hFFFF;
    chk_cnt++; if (ovf !== exp_ovf) begin err_cnt++; $display("[TB] FAIL sat_hit got %h want %h", ovf, exp_ovf); end
    step();
    commit_ack = 2'b00;
    chk_cnt++; if (ovf !== exp_ovf) begin err_cnt++; $display("[TB] FAIL sat_hold got %h want %h", ovf, exp_ovf); end
  endtask

  task automatic test_reset_midstream();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ports(64'h800, 64'h804, 2'b11);
      step();
    end
    set_ports(64'h808, 64'h80c, 2'b01);
    step();
    chk_cnt++; if (level !== 5'd9) begin err_cnt++; $display("[TB] FAIL mid_fill got %0d want 9", level); end
    set_ports(64'h900, 64'h904, 2'b11);
    tr.trace_ready_i = 1'b1;
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    exp_ovf = 16'd0;
    chk_cnt++; if (tr.trace_valid_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL mid_valid got %b want 0", tr.trace_valid_o); end
    chk_cnt++; if (level !== 5'd0 || ovf !== exp_ovf) begin err_cnt++; $display("[TB] FAIL mid_state got level=%0d ovf=%h want 0/0000", level, ovf); end
    commit_ack       = 2'b00;
    tr.trace_ready_i = 1'b0;
    #2;
    rst_ni = 1'b1;
    step();
    set_ports(64'h4000, 64'h4004, 2'b01);
    step();
    commit_ack = 2'b00;
    chk_cnt++; if (level !== 5'd1 || tr.trace_o.seq !== 16'd0) begin err_cnt++; $display("[TB] FAIL mid_seq got level=%0d seq=%0d want 1/0", level, tr.trace_o.seq); end
    chk_cnt++; if (tr.trace_o.pc !== 64'h4000) begin err_cnt++; $display("[TB] FAIL mid_pc got %h want 4000", tr.trace_o.pc); end
  endtask

  task automatic test_disabled();
    en_i = 1'b0;
    set_ports(64'h5000, 64'h5004, 2'b11);
    tr.trace_ready_i = 1'b1;
    step();
    chk_cnt++; if (level !== 5'd0 || ovf !== exp_ovf) begin err_cnt++; $display("[TB] FAIL dis_pop got level=%0d ovf=%h want 0/%h", level, ovf, exp_ovf); end
    tr.trace_ready_i = 1'b0;
    step();
    chk_cnt++; if (tr.trace_valid_o !== 1'b0 || level !== 5'd0) begin err_cnt++; $display("[TB] FAIL dis_nowrite got valid=%b level=%0d want 0/0", tr.trace_valid_o, level); end
    idle();
  endtask

  initial begin
    test_reset();
    test_two_port();
    test_overflow();
    test_flush();
    test_exception();
    test_saturate();
    test_reset_midstream();
    test_disabled();
    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
